// File: rtl/hack_pkg.sv
// Shared definitions for the hack word path: word width, slot count and the
// slot-count helper used by the distributor.
package hack_pkg;

    localparam int WORD_W = 16;
    localparam int NSLOTS = 8;
    localparam int SEL_W  = 3;

    typedef logic [WORD_W-1:0] word_t;

    // Number of set bits in a slot mask (0..NSLOTS).
    function automatic logic [3:0] count_ones(input logic [NSLOTS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NSLOTS; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/word_slot.sv
// One distributor slot: a data register with load and a full flag that is
// set on load and cleared when the consumer takes the word.
module word_slot
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    logic [WIDTH-1:0] data_r;
    logic             full_r;

    // Data register: loaded on accept, deliberately kept on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {WIDTH{1'b0}};
        end else if (load) begin
            data_r <= din;
        end
    end

    // Full flag: load wins, although the top never asserts both together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= 1'b0;
        end else if (load) begin
            full_r <= 1'b1;
        end else if (clear) begin
            full_r <= 1'b0;
        end
    end

    assign data = data_r;
    assign full = full_r;

endmodule

// File: rtl/dmux8way16_buf.sv
// Registered 1-to-8 word distributor: accepts a word under valid/ready into
// the selected slot and holds it until that slot's consumer acknowledges it.
module dmux8way16_buf
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ack,
    output logic [3:0]       occupancy,
    output logic             ack_err
);

    logic [NSLOTS-1:0] full_s;
    logic [NSLOTS-1:0] load_s;
    logic [NSLOTS-1:0] release_s;
    logic              accept_s;
    logic              bad_ack_s;
    logic [3:0]        occ_next_s;
    logic [WIDTH-1:0]  data_s [NSLOTS];
    logic [3:0]        occupancy_r;
    logic              ack_err_r;

    // Readiness depends only on the addressed slot's state: no bypass from acks.
    assign in_ready = ~full_s[sel];
    assign accept_s = in_valid & ~full_s[sel];

    // Load decode, release mask and the occupancy delta for this cycle.
    always_comb begin
        load_s     = {NSLOTS{1'b0}};
        release_s  = out_ack & full_s;
        bad_ack_s  = |(out_ack & ~full_s);
        occ_next_s = occupancy_r;
        if (accept_s) begin
            load_s = 8'h01 << sel;
        end else begin
            load_s = {NSLOTS{1'b0}};
        end
        occ_next_s = occupancy_r + {3'd0, accept_s} - count_ones(release_s);
    end

    // Occupancy counter tracks accepts minus honoured releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_r <= 4'd0;
        end else begin
            occupancy_r <= occ_next_s;
        end
    end

    // Sticky error for any ack that hits an empty slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_err_r <= 1'b0;
        end else if (bad_ack_s) begin
            ack_err_r <= 1'b1;
        end
    end

    for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
        word_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load_s[i]),
            .clear (release_s[i]),
            .din   (in),
            .data  (data_s[i]),
            .full  (full_s[i])
        );
    end

    assign a         = data_s[0];
    assign b         = data_s[1];
    assign c         = data_s[2];
    assign d         = data_s[3];
    assign e         = data_s[4];
    assign f         = data_s[5];
    assign g         = data_s[6];
    assign h         = data_s[7];
    assign out_valid = full_s;
    assign occupancy = occupancy_r;
    assign ack_err   = ack_err_r;

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Self-checking bench for dmux8way16_buf: directed scenarios followed by
// random accept/ack traffic against an array-based slot model.
module tb_dmux8way16_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [2:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  out_valid;
    logic [7:0]  out_ack;
    logic [3:0]  occupancy;
    logic        ack_err;
    logic [15:0] slot_w [8];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what each slot holds, whether it is full, error flag.
    logic [15:0] m_data [8];
    bit          m_full [8];
    bit          m_err;

    always #5 clk = ~clk;

    dmux8way16_buf dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .h         (h),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .occupancy (occupancy),
        .ack_err   (ack_err)
    );

    assign slot_w[0] = a;
    assign slot_w[1] = b;
    assign slot_w[2] = c;
    assign slot_w[3] = d;
    assign slot_w[4] = e;
    assign slot_w[5] = f;
    assign slot_w[6] = g;
    assign slot_w[7] = h;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m_full[i]) n++;
        return n;
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = m_full[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_data[i] = 16'h0000;
            m_full[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".out_valid"}, {24'd0, out_valid}, {24'd0, m_mask()});
        check_eq({tag, ".occupancy"}, {28'd0, occupancy}, m_count());
        check_eq({tag, ".ack_err"}, {31'd0, ack_err}, {31'd0, m_err});
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("%s.slot%0d", tag, i), {16'd0, slot_w[i]}, {16'd0, m_data[i]});
        end
    endtask

    // Drive one cycle of inputs (called right after a falling edge), then
    // advance the model over the rising edge and compare on the next fall.
    task automatic step(input logic v, input logic [2:0] s, input logic [15:0] w,
                        input logic [7:0] k, input string tag);
        bit rdy;
        in_valid = v;
        sel      = s;
        din      = w;
        out_ack  = k;
        #1;
        rdy = !m_full[s];
        check_eq({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                if (m_full[i]) m_full[i] = 1'b0;
                else           m_err     = 1'b1;
            end
        end
        if (v && rdy) begin
            m_data[s] = w;
            m_full[s] = 1'b1;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("reset");
    endtask

    initial begin
        rst      = 1'b1;
        din      = 16'h0000;
        sel      = 3'd0;
        in_valid = 1'b0;
        out_ack  = 8'h00;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all("por");

        // Fill every slot with a walking one.
        for (int s = 0; s < 8; s++) step(1'b1, 3'(s), 16'h0001 << s, 8'h00, "fill");
        check_eq("fill.out_valid_ff", {24'd0, out_valid}, 32'h0000_00ff);
        check_eq("fill.occ8", {28'd0, occupancy}, 32'd8);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            check_eq($sformatf("full.in_ready%0d", s), {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end

        // Stall on full slot 2, then release it and let the held word in.
        for (int n = 0; n < 3; n++) step(1'b1, 3'd2, 16'hBEEF, 8'h00, "stall");
        check_eq("stall.c", {16'd0, c}, 32'h0000_0004);
        step(1'b1, 3'd2, 16'hBEEF, 8'h04, "rel2");
        check_eq("rel2.valid2", {31'd0, out_valid[2]}, 32'd0);
        check_eq("rel2.c", {16'd0, c}, 32'h0000_0004);
        step(1'b1, 3'd2, 16'hBEEF, 8'h00, "acc2");
        check_eq("acc2.c", {16'd0, c}, 32'h0000_beef);

        // Same-cycle accept into slot 5 and release of slot 0.
        do_reset();
        step(1'b1, 3'd0, 16'h0001, 8'h00, "pre5");
        step(1'b1, 3'd5, 16'h1234, 8'h01, "acc5");
        check_eq("acc5.out_valid", {24'd0, out_valid}, 32'h0000_0020);
        check_eq("acc5.f", {16'd0, f}, 32'h0000_1234);
        check_eq("acc5.occ", {28'd0, occupancy}, 32'd1);

        // Ack on an empty slot is sticky through later good traffic.
        step(1'b0, 3'd0, 16'h0000, 8'h80, "badack");
        check_eq("badack.err", {31'd0, ack_err}, 32'd1);
        step(1'b1, 3'd3, 16'h5555, 8'h00, "after1");
        step(1'b0, 3'd0, 16'h0000, 8'h28, "after2");
        check_eq("after.err", {31'd0, ack_err}, 32'd1);

        // Asynchronous reset between edges with four slots full.
        do_reset();
        for (int s = 0; s < 4; s++) step(1'b1, 3'(s * 2), 16'hA000 + 16'(s), 8'h00, "fill4");
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst.out_valid", {24'd0, out_valid}, 32'd0);
        check_eq("arst.occ", {28'd0, occupancy}, 32'd0);
        for (int i = 0; i < 8; i++) check_eq($sformatf("arst.slot%0d", i), {16'd0, slot_w[i]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("arst.after");
        @(negedge clk);

        // Random traffic; acks mostly target full slots, occasionally anything.
        for (int n = 0; n < 10000; n++) begin
            logic [7:0] k;
            k = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 31) != 0) k = k & m_mask();
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom), k, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
